// File: rtl/mode_ctrl.sv
// Frame-synchronous display mode controller: debounced button presses step
// the requested mode, which commits to the mixer only on a vsync rising edge.

module mode_db_stage #(
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_d
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_MAX  = '1;

  logic          btn_m;
  logic          btn_s;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_i;
      btn_s <= btn_m;
    end
  end

  // Any cycle where the synced level matches the held level restarts the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_d  <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_d) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_d  <= btn_s;
      db_cnt <= '0;
    end else if (db_cnt != DB_MAX) begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

endmodule

module mode_press_stage #(
  parameter int unsigned LONG_PRESS = 50000000,
  parameter logic [1:0]  MODE_RST   = 2'b00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_d,
  output logic [1:0] req_o,
  output logic       long_o
);

  localparam int unsigned HW = $clog2(LONG_PRESS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_n;
  logic [1:0]    req_n;
  logic          long_n;
  logic          btn_q;
  logic          press_rise;

  assign press_rise = btn_d & ~btn_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
      req_o    <= MODE_RST;
      long_o   <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      req_o    <= req_n;
      long_o   <= long_n;
      btn_q    <= btn_d;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    req_n   = req_o;
    long_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_rise) begin
          state_n = PRESS;
          hold_n  = '0;
          req_n   = req_o + 2'd1;
        end
      end
      PRESS: begin
        if (!btn_d) begin
          state_n = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = HELD;
          req_n   = MODE_RST;
          long_n  = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      HELD: begin
        if (!btn_d) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

module mode_commit_stage #(
  parameter logic [1:0] MODE_RST = 2'b00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vs_i,
  input  logic [1:0] req_i,
  output logic [1:0] mode_o
);

  logic vs_q;
  logic vs_arm;
  logic vs_rise;

  // vs_arm blocks a commit when vsync is already high as reset releases
  assign vs_rise = vs_i & ~vs_q & vs_arm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q   <= 1'b0;
      vs_arm <= 1'b0;
      mode_o <= MODE_RST;
    end else begin
      vs_q   <= vs_i;
      vs_arm <= vs_arm | ~vs_i;
      if (vs_rise) begin
        mode_o <= req_i;
      end
    end
  end

endmodule

module mode_ctrl #(
  parameter int unsigned DEBOUNCE   = 500000,
  parameter int unsigned LONG_PRESS = 50000000,
  parameter logic [1:0]  MODE_RST   = 2'b00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       vs_i,
  output logic [1:0] mode_o,
  output logic [1:0] req_o,
  output logic       pending_o,
  output logic       long_o
);

  logic btn_d;

  mode_db_stage #(
    .DEBOUNCE(DEBOUNCE)
  ) u_db (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_i(btn_i),
    .btn_d(btn_d)
  );

  mode_press_stage #(
    .LONG_PRESS(LONG_PRESS),
    .MODE_RST(MODE_RST)
  ) u_press (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .btn_d (btn_d),
    .req_o (req_o),
    .long_o(long_o)
  );

  mode_commit_stage #(
    .MODE_RST(MODE_RST)
  ) u_commit (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vs_i  (vs_i),
    .req_i (req_o),
    .mode_o(mode_o)
  );

  assign pending_o = (req_o != mode_o);

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with DEBOUNCE=4, LONG_PRESS=16, MODE_RST=0.
// Inputs change 1ns after a rising edge; outputs are checked at that point.

module tb_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       vs;
  logic [1:0] mode;
  logic [1:0] req;
  logic       pending;
  logic       long_p;

  int n_chk    = 0;
  int n_fail   = 0;
  int long_cnt = 0;
  int db_max   = 0;
  int long_base;

  always #5 clk = ~clk;

  mode_ctrl #(
    .DEBOUNCE  (4),
    .LONG_PRESS(16),
    .MODE_RST  (2'b00)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_i    (btn),
    .vs_i     (vs),
    .mode_o   (mode),
    .req_o    (req),
    .pending_o(pending),
    .long_o   (long_p)
  );

  always @(negedge clk) begin
    if (long_p === 1'b1) long_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {mode, req, pending, long}
  function automatic logic [7:0] outs();
    return {2'b00, mode, req, pending, long_p};
  endfunction

  task automatic press_chk(input string tag, input logic [1:0] exp_req);
    btn = 1'b1;
    cyc(6);
    chk({tag, "_pre"}, {6'd0, req}, {6'd0, exp_req - 2'd1});
    cyc(1);
    chk(tag, {6'd0, req}, {6'd0, exp_req});
    cyc(3);
    btn = 1'b0;
    cyc(10);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    vs  = 1'b0;
    cyc(2);
    chk("reset_outs", outs(), 8'h00);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle_outs", outs(), 8'h00);
    end

    // 2: single press, then commit
    btn = 1'b1;
    cyc(6);
    chk("p1_req_t6", {6'd0, req}, 8'd0);
    cyc(1);
    chk("p1_req_t7", {6'd0, req}, 8'd1);
    chk("p1_pend_t7", {7'd0, pending}, 8'd1);
    chk("p1_mode_t7", {6'd0, mode}, 8'd0);
    cyc(3);
    btn = 1'b0;
    cyc(9);
    chk("p1_pend_t19", {7'd0, pending}, 8'd1);
    chk("p1_mode_t19", {6'd0, mode}, 8'd0);
    vs = 1'b1;
    cyc(1);
    chk("p1_mode_t20", {6'd0, mode}, 8'd1);
    chk("p1_pend_t20", {7'd0, pending}, 8'd0);
    vs = 1'b0;
    cyc(10);

    // 3: 1-on/1-off chatter must never debounce
    db_max = 0;
    for (int i = 0; i < 30; i++) begin
      btn = (i % 2 == 0);
      cyc(1);
      if (int'(u_dut.u_db.db_cnt) > db_max) db_max = int'(u_dut.u_db.db_cnt);
    end
    btn = 1'b0;
    cyc(10);
    chk("glitch_req", {6'd0, req}, 8'd1);
    chk("glitch_dbmax_lt3", {7'd0, db_max < 3}, 8'd1);
    chk("glitch_long_none", long_cnt[7:0], 8'd0);

    // 4: four presses wrap to 0 within one frame
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("p4_reset_outs", outs(), 8'h00);
    press_chk("p4_req1", 2'd1);
    chk("p4_pend1", {7'd0, pending}, 8'd1);
    press_chk("p4_req2", 2'd2);
    press_chk("p4_req3", 2'd3);
    press_chk("p4_req0", 2'd0);
    chk("p4_mode_after4", {6'd0, mode}, 8'd0);
    chk("p4_pend_after4", {7'd0, pending}, 8'd0);
    vs = 1'b1;
    cyc(1);
    vs = 1'b0;
    chk("p4_mode_commit", {6'd0, mode}, 8'd0);
    cyc(5);

    // 5: vsync rise on the same edge as the increment
    btn = 1'b1;
    cyc(6);
    vs = 1'b1;
    cyc(1);
    chk("p5_req", {6'd0, req}, 8'd1);
    chk("p5_mode_same_edge", {6'd0, mode}, 8'd0);
    chk("p5_pend", {7'd0, pending}, 8'd1);
    cyc(3);
    btn = 1'b0;
    chk("p5_mode_vs_held", {6'd0, mode}, 8'd0);
    vs = 1'b0;
    cyc(10);
    chk("p5_pend_frame", {7'd0, pending}, 8'd1);
    vs = 1'b1;
    cyc(1);
    chk("p5_mode_next", {6'd0, mode}, 8'd1);
    chk("p5_pend_next", {7'd0, pending}, 8'd0);
    vs = 1'b0;
    cyc(5);

    // 6: long press from req=2, then reset mid-hold
    press_chk("p6_req2", 2'd2);
    long_base = long_cnt;
    btn = 1'b1;
    cyc(7);
    chk("p6_req3", {6'd0, req}, 8'd3);
    cyc(15);
    chk("p6_long_early", {7'd0, long_p}, 8'd0);
    chk("p6_req3_hold", {6'd0, req}, 8'd3);
    cyc(1);
    chk("p6_long_pulse", {7'd0, long_p}, 8'd1);
    chk("p6_req_rst", {6'd0, req}, 8'd0);
    cyc(1);
    chk("p6_long_end", {7'd0, long_p}, 8'd0);
    cyc(4);
    chk("p6_long_once", 8'(long_cnt - long_base), 8'd1);
    chk("p6_mode_pre_rst", {6'd0, mode}, 8'd1);
    rst = 1'b1;
    #1;
    chk("p6_async_rst", outs(), 8'h00);
    cyc(1);
    rst = 1'b0;
    cyc(6);
    chk("p6_rearm_t6", {6'd0, req}, 8'd0);
    cyc(1);
    chk("p6_rearm_t7", {6'd0, req}, 8'd1);
    btn = 1'b0;
    cyc(20);
    chk("p6_long_total", 8'(long_cnt - long_base), 8'd1);
    chk("p6_final_pend", {7'd0, pending}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
